// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_side_t  - sideband bundle carried from EXU to WBU untouched
//   lsu_state_e - LSU control states
//   AXI response codes and load-mask encodings
package lsu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STRB_W     = XLEN / 8;
    localparam int unsigned RESP_W     = 2;
    localparam int unsigned WMASK_IN_W = 8;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    localparam logic [XLEN-1:0] RMASK_BYTE = 32'h0000_00FF;
    localparam logic [XLEN-1:0] RMASK_HALF = 32'h0000_FFFF;
    localparam logic [XLEN-1:0] RMASK_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [4:0]      rd;
        logic [1:0]      csr_rd;
        logic [1:0]      wdOp;
        logic            reg_write_en;
        logic            csreg_write_en;
        logic            ecall;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
    } lsu_side_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WREQ = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for the LSU.
//   Store side: shifts store data and byte strobe to the addressed lane.
//   Load side : shifts read data down, applies the load mask and optionally
//               sign-extends byte/half loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        store_addr_lo,
    input  logic [XLEN-1:0]   store_data,
    input  logic [STRB_W-1:0] store_mask,
    input  logic [1:0]        load_addr_lo,
    input  logic [XLEN-1:0]   load_raw,
    input  logic [XLEN-1:0]   load_mask,
    input  logic              load_signed,
    output logic [XLEN-1:0]   store_wdata_c,
    output logic [STRB_W-1:0] store_wstrb_c,
    output logic [XLEN-1:0]   load_data_c
);

    logic [4:0]      store_shamt;
    logic [4:0]      load_shamt;
    logic [XLEN-1:0] load_masked;

    // Store lane placement; strobe bits shifted past lane 3 are dropped.
    always_comb begin
        store_shamt   = {store_addr_lo, 3'b000};
        store_wdata_c = store_data << store_shamt;
        store_wstrb_c = store_mask << store_addr_lo;
    end

    // Load extraction and optional sign extension.
    always_comb begin
        load_shamt  = {load_addr_lo, 3'b000};
        load_masked = (load_raw >> load_shamt) & load_mask;
        load_data_c = load_masked;
        if (load_signed) begin
            if (load_mask == RMASK_BYTE) begin
                load_data_c = {{24{load_masked[7]}}, load_masked[7:0]};
            end else if (load_mask == RMASK_HALF) begin
                load_data_c = {{16{load_masked[15]}}, load_masked[15:0]};
            end
        end
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-occupancy load/store stage between EXU and WBU.
//   EXU side : in_valid/in_ready handshake plus instruction fields.
//   AXI4-Lite: AR/R for loads, AW/W/B for stores (at most one access).
//   WBU side : out_valid/out_ready with result, alu_result, side, mem_err.
// All outputs are flops; control valids are decoded from the next state.
module lsu
    import lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_result_input,
    input  logic [XLEN-1:0]       src2_input,
    input  logic                  ren_input,
    input  logic                  wen_input,
    input  logic [WMASK_IN_W-1:0] wmask_input,
    input  logic [XLEN-1:0]       rmask_input,
    input  logic                  memory_read_signed_input,
    input  lsu_side_t             side_input,
    output logic [XLEN-1:0]       araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [XLEN-1:0]       rdata,
    input  logic [RESP_W-1:0]     rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [XLEN-1:0]       awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [XLEN-1:0]       wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [RESP_W-1:0]     bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       result,
    output logic [XLEN-1:0]       alu_result,
    output lsu_side_t             side,
    output logic                  mem_err
);

    lsu_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   araddr_q, araddr_d;
    logic [XLEN-1:0]   awaddr_q, awaddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    lsu_side_t         side_q, side_d;
    logic              mem_err_q, mem_err_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]   rmask_q, rmask_d;
    logic              signed_q, signed_d;

    logic [XLEN-1:0]   store_wdata_c;
    logic [STRB_W-1:0] store_wstrb_c;
    logic [XLEN-1:0]   load_data_c;
    logic              aw_ok_c;
    logic              w_ok_c;
    logic              unused_wmask_hi_c;

    // Upper store-mask bits carry no meaning for a 32-bit bus.
    assign unused_wmask_hi_c = ^wmask_input[WMASK_IN_W-1:STRB_W];

    lsu_align u_align (
        .store_addr_lo (alu_result_input[1:0]),
        .store_data    (src2_input),
        .store_mask    (wmask_input[STRB_W-1:0]),
        .load_addr_lo  (addr_lo_q),
        .load_raw      (rdata),
        .load_mask     (rmask_q),
        .load_signed   (signed_q),
        .store_wdata_c (store_wdata_c),
        .store_wstrb_c (store_wstrb_c),
        .load_data_c   (load_data_c)
    );

    // A write channel is finished once its valid has dropped or is handshaking now.
    assign aw_ok_c = !awvalid_q || awready;
    assign w_ok_c  = !wvalid_q  || wready;

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        result_d     = result_q;
        alu_result_d = alu_result_q;
        side_d       = side_q;
        mem_err_d    = mem_err_q;
        addr_lo_d    = addr_lo_q;
        rmask_d      = rmask_q;
        signed_d     = signed_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    alu_result_d = alu_result_input;
                    result_d     = alu_result_input;
                    side_d       = side_input;
                    mem_err_d    = 1'b0;
                    addr_lo_d    = alu_result_input[1:0];
                    rmask_d      = rmask_input;
                    signed_d     = memory_read_signed_input;
                    if (ren_input) begin
                        araddr_d = alu_result_input;
                        state_d  = S_AR;
                    end else if (wen_input) begin
                        awaddr_d = alu_result_input;
                        wdata_d  = store_wdata_c;
                        wstrb_d  = store_wstrb_c;
                        state_d  = S_WREQ;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    result_d  = load_data_c;
                    mem_err_d = (rresp != RESP_OKAY);
                    state_d   = S_DONE;
                end
            end
            S_WREQ: begin
                if (aw_ok_c && w_ok_c) state_d = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    mem_err_d = (bresp != RESP_OKAY);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        arvalid_d   = (state_d == S_AR);
        rready_d    = (state_d == S_R);
        bready_d    = (state_d == S_B);
        out_valid_d = (state_d == S_DONE);

        // Both write valids rise on entry to WREQ and drop after their own handshake.
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_d == S_WREQ) begin
            if (state_q != S_WREQ) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end else begin
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q  && !wready;
            end
        end
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            result_q     <= '0;
            alu_result_q <= '0;
            side_q       <= '0;
            mem_err_q    <= 1'b0;
            addr_lo_q    <= '0;
            rmask_q      <= '0;
            signed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            out_valid_q  <= out_valid_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            result_q     <= result_d;
            alu_result_q <= alu_result_d;
            side_q       <= side_d;
            mem_err_q    <= mem_err_d;
            addr_lo_q    <= addr_lo_d;
            rmask_q      <= rmask_d;
            signed_q     <= signed_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = awaddr_q;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign alu_result = alu_result_q;
    assign side       = side_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scenario tasks for the LSU with a scoreboard of expected WBU results.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] alu;
        logic        mem_err;
        lsu_side_t   side;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_input;
    logic [31:0] src2_input;
    logic        ren_input;
    logic        wen_input;
    logic [7:0]  wmask_input;
    logic [31:0] rmask_input;
    logic        memory_read_signed_input;
    lsu_side_t   side_input;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] alu_result;
    lsu_side_t   side;
    logic        mem_err;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_input(alu_result_input), .src2_input(src2_input),
        .ren_input(ren_input), .wen_input(wen_input),
        .wmask_input(wmask_input), .rmask_input(rmask_input),
        .memory_read_signed_input(memory_read_signed_input),
        .side_input(side_input),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .alu_result(alu_result), .side(side), .mem_err(mem_err)
    );

    // Scoreboard: every WBU handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_valid with result=%h but no expected entry", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.result) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h expected %h", result, e.result);
                end
                n_cmp++;
                if (alu_result !== e.alu) begin
                    n_fail++;
                    $display("FAIL sb_alu_result: got %h expected %h", alu_result, e.alu);
                end
                n_cmp++;
                if (mem_err !== e.mem_err) begin
                    n_fail++;
                    $display("FAIL sb_mem_err: got %b expected %b", mem_err, e.mem_err);
                end
                n_cmp++;
                if (side !== e.side) begin
                    n_fail++;
                    $display("FAIL sb_side: got %h expected %h", side, e.side);
                end
            end
        end
    end

    function automatic lsu_side_t mk_side(input int unsigned seed);
        lsu_side_t s;
        s.rd             = 5'(seed);
        s.csr_rd         = 2'(seed >> 5);
        s.wdOp           = 2'(seed >> 7);
        s.reg_write_en   = seed[9];
        s.csreg_write_en = seed[10];
        s.ecall          = seed[11];
        s.pc             = 32'h8000_0000 + 32'(seed * 4);
        s.pc_next        = 32'h8000_0004 + 32'(seed * 4);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one clock edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] s2, input logic rn,
                         input logic wn, input logic [7:0] wm, input logic [31:0] rm,
                         input logic sg, input lsu_side_t sd);
        in_valid                 = 1'b1;
        alu_result_input         = a;
        src2_input               = s2;
        ren_input                = rn;
        wen_input                = wn;
        wmask_input              = wm;
        rmask_input              = rm;
        memory_read_signed_input = sg;
        side_input               = sd;
        step();
        in_valid  = 1'b0;
        ren_input = 1'b0;
        wen_input = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_cmp++;
        if ({arvalid, rready, awvalid, wvalid, bready, out_valid, mem_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 0", {arvalid, rready, awvalid, wvalid, bready, out_valid, mem_err});
        end
        n_cmp++;
        if ({result, alu_result, araddr, awaddr, wdata, wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h alu=%h araddr=%h awaddr=%h wdata=%h wstrb=%h expected all 0",
                     result, alu_result, araddr, awaddr, wdata, wstrb);
        end
    endtask

    // Non-memory op: out_valid exactly one cycle after accept, no AXI traffic.
    task automatic alu_op(input logic [31:0] a, input int unsigned seed, input string nm);
        lsu_side_t sd;
        sd = mk_side(seed);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready_before: got %b expected 1", nm, in_ready);
        end
        exp_q.push_back('{result: a, alu: a, mem_err: 1'b0, side: sd});
        issue(a, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, sd);
        n_cmp++;
        if ({out_valid, in_ready, arvalid, awvalid, wvalid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got ov/ir/ar/aw/w=%b expected 10000", nm,
                     {out_valid, in_ready, arvalid, awvalid, wvalid});
        end
        step();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_release: got ov/ir=%b expected 01", nm, {out_valid, in_ready});
        end
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        alu_op(32'h0000_1234, 32'h2A5, "alu");
    endtask

    // Load with a zero-wait slave on AR and R.
    task automatic load_op(input logic [31:0] a, input logic [31:0] rm, input logic sg,
                           input logic [31:0] rd, input logic [1:0] rsp,
                           input logic [31:0] exp_res, input string nm);
        lsu_side_t sd;
        sd = mk_side(a[11:0]);
        exp_q.push_back('{result: exp_res, alu: a, mem_err: (rsp != 2'b00), side: sd});
        issue(a, 32'h0, 1'b1, 1'b0, 8'h0, rm, sg, sd);
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== a) begin
            n_fail++;
            $display("FAIL %s_ar: got arvalid=%b araddr=%h expected 1 %h", nm, arvalid, araddr, a);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        n_cmp++;
        if ({arvalid, rready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_r: got arvalid/rready=%b expected 01", nm, {arvalid, rready});
        end
        rvalid = 1'b1;
        rdata  = rd;
        rresp  = rsp;
        step();
        rvalid = 1'b0;
        n_cmp++;
        if ({out_valid, rready} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_done: got out_valid/rready=%b expected 10", nm, {out_valid, rready});
        end
    endtask

    task automatic test_load();
        out_ready = 1'b1;
        load_op(32'h8000_0003, RMASK_BYTE, 1'b1, 32'h80FF_FFFF, RESP_OKAY, 32'hFFFF_FF80, "lb");
        step();
        load_op(32'h8000_0002, RMASK_HALF, 1'b0, 32'hBEEF_1234, RESP_OKAY, 32'h0000_BEEF, "lhu");
        step();
        load_op(32'h8000_0001, RMASK_BYTE, 1'b0, 32'h1234_9A78, RESP_OKAY, 32'h0000_009A, "lbu");
        step();
    endtask

    task automatic test_store();
        lsu_side_t sd;
        out_ready = 1'b1;
        sd = mk_side(32'h5C3);
        exp_q.push_back('{result: 32'h8000_0002, alu: 32'h8000_0002, mem_err: 1'b0, side: sd});
        issue(32'h8000_0002, 32'h0000_ABCD, 1'b0, 1'b1, 8'hF3, 32'h0, 1'b0, sd);
        n_cmp++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h8000_0002) begin
            n_fail++;
            $display("FAIL st_req: got aw/w=%b awaddr=%h expected 11 80000002", {awvalid, wvalid}, awaddr);
        end
        n_cmp++;
        if (wdata !== 32'hABCD_0000 || wstrb !== 4'hC) begin
            n_fail++;
            $display("FAIL st_lane: got wdata=%h wstrb=%h expected abcd0000 c", wdata, wstrb);
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b010) begin
            n_fail++;
            $display("FAIL st_aw_done: got aw/w/b=%b expected 010", {awvalid, wvalid, bready});
        end
        step();
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b010) begin
            n_fail++;
            $display("FAIL st_w_wait: got aw/w/b=%b expected 010", {awvalid, wvalid, bready});
        end
        wready = 1'b1;
        step();
        wready = 1'b0;
        n_cmp++;
        if ({awvalid, wvalid, bready, out_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL st_b: got aw/w/b/ov=%b expected 0010", {awvalid, wvalid, bready, out_valid});
        end
        bvalid = 1'b1;
        bresp  = RESP_OKAY;
        step();
        bvalid = 1'b0;
        n_cmp++;
        if ({bready, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL st_done: got b/ov=%b expected 01", {bready, out_valid});
        end
        step();
    endtask

    // SLVERR load, then WBU stalls for five cycles.
    task automatic test_err_hold();
        out_ready = 1'b0;
        load_op(32'h8000_0010, RMASK_WORD, 1'b0, 32'hDEAD_BEEF, RESP_SLVERR, 32'hDEAD_BEEF, "err");
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, mem_err} !== 3'b101 || result !== 32'hDEAD_BEEF
                || alu_result !== 32'h8000_0010) begin
                n_fail++;
                $display("FAIL hold_%0d: got ov/ir/err=%b result=%h alu=%h expected 101 deadbeef 80000010",
                         i, {out_valid, in_ready, mem_err}, result, alu_result);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release: got ov/ir=%b expected 01", {out_valid, in_ready});
        end
    endtask

    // Reset lands while a read response is pending.
    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(32'h8000_0020, 32'h0, 1'b1, 1'b0, 8'h0, RMASK_WORD, 1'b0, mk_side(32'h77));
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h1111_2222;
        rresp   = RESP_OKAY;
        rst     = 1'b1;
        step();
        rst    = 1'b0;
        rvalid = 1'b0;
        n_cmp++;
        if ({arvalid, rready, awvalid, wvalid, bready, out_valid, in_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL rst_mid: got ar/r/aw/w/b/ov/ir=%b expected 0000001",
                     {arvalid, rready, awvalid, wvalid, bready, out_valid, in_ready});
        end
        alu_op(32'hCAFE_0001, 32'h3F1, "post_rst");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_op($urandom, $urandom_range(0, 4095), "b2b");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_result_input = '0; src2_input = '0;
        ren_input = 1'b0; wen_input = 1'b0; wmask_input = '0; rmask_input = '0;
        memory_read_signed_input = 1'b0; side_input = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_err_hold();
        test_reset_mid();
        test_back_to_back();
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit, the consumer of the EXU output handshake: it accepts one executed instruction from the EXU, performs at most one data-memory access over an AXI4-Lite master port, then presents the result and the sideband bundle to the WBU. It is a single-occupancy stage with no internal queueing. It is the receiver for the EXU's `exu_send_valid` and supplies the EXU's `exu_receive_ready`.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  EXU has an instruction (`exu_send_valid`)
- in_ready  out  1  LSU can accept (drives EXU `exu_receive_ready`)
- alu_result_input  in  32  address for memory ops, result otherwise
- src2_input  in  32  store data
- ren_input / wen_input  in  1 each  load / store; never both set
- wmask_input  in  8  store byte mask, bits [3:0] used (1, 3, F); [7:4] ignored
- rmask_input  in  32  load mask: 0xFF, 0xFFFF, 0xFFFFFFFF
- memory_read_signed_input  in  1  sign-extend load
- side_input  in  lsu_side_t  passthrough bundle
- araddr / arvalid / arready  out / out / in  32 / 1 / 1  AXI read address
- rdata / rresp / rvalid / rready  in / in / in / out  32 / 2 / 1 / 1  AXI read data
- awaddr / awvalid / awready  out / out / in  32 / 1 / 1  AXI write address
- wdata / wstrb / wvalid / wready  out / out / out / in  32 / 4 / 1 / 1  AXI write data
- bresp / bvalid / bready  in / in / out  2 / 1 / 1  AXI write response
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts
- result  out  32  extended load data if load, else alu_result
- alu_result  out  32  registered alu_result_input
- side  out  lsu_side_t  registered side_input
- mem_err  out  1  rresp/bresp was nonzero

## Operation
- States: IDLE, AR, R, WREQ, B, DONE.
- IDLE: in_ready=1. On in_valid, capture all inputs. Next state is AR if ren, WREQ if wen, otherwise DONE.
- AR: arvalid=1, araddr=captured address (full byte address). On arready, go to R.
- R: rready=1. On rvalid, capture rdata and rresp, then go to DONE.
- Load extension: data = (rdata >> 8*addr[1:0]) & rmask. If signed, sign-extend from bit 7 (mask 0xFF) or bit 15 (mask 0xFFFF).
- WREQ: awvalid and wvalid assert together.
  - awaddr = address.
  - wdata = src2 << 8*addr[1:0].
  - wstrb = wmask[3:0] << addr[1:0], truncated to 4 bits.
  - Each valid drops independently after its own handshake. Go to B once both have handshaken (same or different cycles).
- B: bready=1. On bvalid, capture bresp, then go to DONE.
- DONE: out_valid=1 with result, alu_result, side and mem_err stable. On out_ready, go to IDLE.
- mem_err = captured resp != 0. The instruction still completes; trapping is the WBU's job.
- Accesses crossing a word boundary are unsupported and their result is unspecified.

## Timing
- in_ready, arvalid, rready, awvalid, wvalid, bready and out_valid are decoded from registered state and never combinationally from inputs.
- Reset values: state IDLE; every output 0 except in_ready=1.
- Non-memory op accepted at cycle T: out_valid at T+1.
- Load with arready=1 at T+1 and rvalid at T+2: out_valid at T+3. Store with zero-wait slave: out_valid at T+3.
- Transfer completes out of DONE on out_valid&&out_ready. in_ready rises the cycle after, so there is one bubble per instruction.
- A response arriving in the same cycle as the address handshake is not legal in AXI and need not be handled.
- Outputs hold while out_ready=0, for unbounded time.
- Reset mid-transaction drops all valids next cycle and returns to IDLE. The memory slave is reset by the same rst.

## Structure
- The shared cpu package holds:
  - `lsu_side_t`, a packed struct: rd[4:0], csr_rd[1:0], wdOp[1:0], reg_write_en, csreg_write_en, ecall, pc[31:0], pc_next[31:0].
  - the state enum `lsu_state_e`.
  - AXI resp constants OKAY=2'b00 and SLVERR=2'b10.
- One combinational sub-module, `lsu_align`, covers store shift/strobe and load shift/mask/extend.

## Test plan
- ALU op alu_result=0x1234, out_ready=1: out_valid one cycle after accept, result=0x1234, side echoed, no AXI valids asserted.
- Load byte signed at 0x80000003, rdata=0x80FFFFFF: result=0xFFFFFF80. Unsigned lhu at 0x80000002, rdata=0xBEEF1234: result=0x0000BEEF.
- Store half at 0x80000002, src2=0x0000ABCD, wmask=3: wstrb=4'hC, wdata=0xABCD0000. Slave gives awready two cycles before wready; completes after bvalid.
- Slave returns rresp=SLVERR: out_valid with mem_err=1. Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0 throughout.
- Assert rst while in R with rvalid pending: next cycle all valids 0, in_ready=1. A fresh ALU op then completes normally.
